// File: rtl/rs_pkg.sv
// rtl/rs_pkg.sv - RS(7,5) over GF(2^3) constants, FSM state type and GF multiply helper
package rs_pkg;

  localparam int SYMBOL_WIDTH = 3;
  localparam int N            = 7;
  localparam int K            = 5;

  localparam logic [3:0] PRIM_POLY = 4'b1011;

  // g(x) = (x+a)(x+a^2) = x^2 + a^4*x + a^3
  localparam logic [SYMBOL_WIDTH-1:0] G1 = 3'b110;
  localparam logic [SYMBOL_WIDTH-1:0] G0 = 3'b011;

  typedef enum logic {
    MSG    = 1'b0,
    PARITY = 1'b1
  } rs_state_e;

  function automatic logic [SYMBOL_WIDTH-1:0] gf8_mul(
    input logic [SYMBOL_WIDTH-1:0] a,
    input logic [SYMBOL_WIDTH-1:0] b
  );
    logic [SYMBOL_WIDTH-1:0] acc;
    logic [SYMBOL_WIDTH-1:0] x;
    acc = '0;
    x   = a;
    for (int i = 0; i < SYMBOL_WIDTH; i++) begin
      if (b[i]) acc = acc ^ x;
      x = {x[SYMBOL_WIDTH-2:0], 1'b0} ^ (x[SYMBOL_WIDTH-1] ? PRIM_POLY[SYMBOL_WIDTH-1:0] : '0);
    end
    return acc;
  endfunction

endpackage

// File: rtl/rs_encoder_stream_gf8_const_mul.sv
// rtl/rs_encoder_stream_gf8_const_mul.sv - combinational GF(2^3) multiply by a fixed constant
module gf8_const_mul
#(
  parameter logic [2:0] C = 3'b001
) (
  input  logic [2:0] a,
  output logic [2:0] y
);

  import rs_pkg::*;

  // Constant operand folds the multiply down to a 3x3 XOR network.
  always_comb begin
    y = gf8_mul(a, C);
  end

endmodule

// File: rtl/rs_encoder_stream.sv
// rtl/rs_encoder_stream.sv - streaming systematic RS(7,5) encoder with registered valid/ready output
module rs_encoder_stream
#(
  parameter int SYMBOL_WIDTH = 3,
  parameter int N            = 7,
  parameter int K            = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [SYMBOL_WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [SYMBOL_WIDTH-1:0] out_data,
  output logic                    out_last
);

  import rs_pkg::*;

  localparam int CNT_W = $clog2(N);

  rs_state_e               state_q;
  rs_state_e               state_d;
  logic [CNT_W-1:0]        msg_cnt;
  logic                    pidx;
  logic [SYMBOL_WIDTH-1:0] r1;
  logic [SYMBOL_WIDTH-1:0] r0;
  logic [SYMBOL_WIDTH-1:0] fb;
  logic [SYMBOL_WIDTH-1:0] fb_g1;
  logic [SYMBOL_WIDTH-1:0] fb_g0;
  logic                    slot_free;
  logic                    accept;
  logic                    last_msg;
  logic                    load_p1;
  logic                    load_p0;

  assign fb = in_data ^ r1;

  gf8_const_mul #(.C(G1)) u_mul_g1 (
    .a (fb),
    .y (fb_g1)
  );

  gf8_const_mul #(.C(G0)) u_mul_g0 (
    .a (fb),
    .y (fb_g0)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= MSG;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      MSG:     if (accept && last_msg) state_d = PARITY;
      PARITY:  if (load_p0)            state_d = MSG;
      default: state_d = MSG;
    endcase
  end

  // in_ready sees out_ready combinationally but never in_valid.
  always_comb begin
    slot_free = !out_valid || out_ready;
    in_ready  = 1'b0;
    load_p1   = 1'b0;
    load_p0   = 1'b0;
    case (state_q)
      MSG:    in_ready = slot_free && !rst;
      PARITY: begin
        load_p1 = slot_free && !pidx;
        load_p0 = slot_free && pidx;
      end
      default: in_ready = 1'b0;
    endcase
    accept   = in_valid && in_ready;
    last_msg = (msg_cnt == CNT_W'(K - 1));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      msg_cnt   <= '0;
      pidx      <= 1'b0;
      r1        <= '0;
      r0        <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else if (accept) begin
      out_data  <= in_data;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      r1        <= r0 ^ fb_g1;
      r0        <= fb_g0;
      if (last_msg) begin
        msg_cnt <= '0;
        pidx    <= 1'b0;
      end else begin
        msg_cnt <= msg_cnt + 1'b1;
      end
    end else if (load_p1) begin
      out_data  <= r1;
      out_valid <= 1'b1;
      out_last  <= 1'b0;
      pidx      <= 1'b1;
    end else if (load_p0) begin
      // Clearing the LFSR here lets the next frame start on the very next accept.
      out_data  <= r0;
      out_valid <= 1'b1;
      out_last  <= 1'b1;
      pidx      <= 1'b0;
      r1        <= '0;
      r0        <= '0;
    end else if (slot_free) begin
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_rs_encoder_stream.sv
// tb/tb_rs_encoder_stream.sv - scoreboard bench for rs_encoder_stream against a polynomial-division model
module tb_rs_encoder_stream;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [2:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_data;
  logic       out_last;

  always #5 clk = ~clk;

  rs_encoder_stream #(.SYMBOL_WIDTH(3), .N(7), .K(5)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_last  (out_last)
  );

  typedef struct packed {
    logic [2:0] d;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   xfer_cyc[$];
  int   tests = 0;
  int   fails = 0;
  int   cyc   = 0;
  bit   rand_ready = 1'b0;

  always @(posedge clk) cyc++;

  always @(posedge clk) begin
    #1 out_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // GF(8) multiply through log/antilog tables of alpha = x.
  function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
    logic [2:0] pw[7] = '{3'd1, 3'd2, 3'd4, 3'd3, 3'd6, 3'd7, 3'd5};
    int la = 0;
    int lb = 0;
    if (a == 0 || b == 0) return 3'd0;
    for (int i = 0; i < 7; i++) begin
      if (pw[i] == a) la = i;
      if (pw[i] == b) lb = i;
    end
    return pw[(la + lb) % 7];
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Remainder of m(x)*x^2 divided by g(x) = x^2 + 6x + 3 by long division.
  task automatic model_push(input logic [2:0] msg[5]);
    logic [2:0] c[7];
    logic [2:0] q;
    exp_t e;
    for (int i = 0; i < 5; i++) c[i] = msg[i];
    c[5] = 3'd0;
    c[6] = 3'd0;
    for (int i = 0; i < 5; i++) begin
      q = c[i];
      c[i]   = 3'd0;
      c[i+1] = c[i+1] ^ gf_mul(q, 3'd6);
      c[i+2] = c[i+2] ^ gf_mul(q, 3'd3);
    end
    for (int i = 0; i < 7; i++) begin
      e.d = (i < 5) ? msg[i] : c[i];
      e.l = (i == 6);
      exp_q.push_back(e);
    end
  endtask

  logic [2:0] fbuf[$];
  bit         stalled = 1'b0;
  logic [2:0] held_d;
  logic       held_l;

  always @(negedge clk) begin
    exp_t       e;
    logic [2:0] s1;
    logic [2:0] s2;
    if (rst) begin
      fbuf.delete();
      stalled = 1'b0;
    end else begin
      if (stalled) begin
        tests++;
        if (!out_valid || out_data !== held_d || out_last !== held_l) begin
          fails++;
          $display("[TB] FAIL stall_hold: got v=%0b d=%0d l=%0b expected v=1 d=%0d l=%0b",
                   out_valid, out_data, out_last, held_d, held_l);
        end
      end
      if (out_valid && out_ready) begin
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("[TB] FAIL unexpected_output: got d=%0d with empty scoreboard expected none", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e.d || out_last !== e.l) begin
            fails++;
            $display("[TB] FAIL codeword_symbol: got d=%0d l=%0b expected d=%0d l=%0b",
                     out_data, out_last, e.d, e.l);
          end
        end
        xfer_cyc.push_back(cyc);
        fbuf.push_back(out_data);
        if (out_last) begin
          s1 = 3'd0;
          s2 = 3'd0;
          foreach (fbuf[i]) begin
            s1 = gf_mul(s1, 3'd2) ^ fbuf[i];
            s2 = gf_mul(s2, 3'd4) ^ fbuf[i];
          end
          chk("frame_len", fbuf.size(), 7);
          chk("syndromes", {s1, s2}, 0);
          fbuf.delete();
        end
      end
      stalled = out_valid && !out_ready;
      held_d  = out_data;
      held_l  = out_last;
    end
  end

  task automatic send_sym(input logic [2:0] d);
    bit ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
    if (ok) begin
      @(posedge clk);
      #1;
    end else begin
      tests++;
      fails++;
      $display("[TB] FAIL accept_timeout: got no in_ready in 200 cycles expected accept");
    end
  endtask

  task automatic send_frame(input logic [2:0] msg[5], input bit gaps);
    model_push(msg);
    for (int i = 0; i < 5; i++) begin
      if (gaps && $urandom_range(0, 1) == 1) begin
        in_valid = 1'b0;
        in_data  = 3'($urandom_range(0, 7));
        repeat ($urandom_range(1, 3)) @(posedge clk);
        #1;
      end
      send_sym(msg[i]);
    end
  endtask

  task automatic drain();
    int n = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && n < 5000) begin
      @(posedge clk);
      n++;
    end
    #1;
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("[TB] FAIL drain_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    logic [2:0] m[5];
    logic [2:0] z[5];
    logic [2:0] one[5];
    exp_t e;
    z   = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd0};
    one = '{3'd1, 3'd0, 3'd0, 3'd0, 3'd0};

    rst       = 1'b1;
    in_valid  = 1'b1;
    in_data   = 3'd5;
    out_ready = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_last", out_last, 0);
      chk("rst_in_ready", in_ready, 0);
      chk("rst_out_data", out_data, 0);
    end
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    send_frame(z, 1'b0);
    drain();
    send_frame(one, 1'b0);
    drain();
    // Parity of 1,0,0,0,0 fixed independently of the model.
    chk("model_ref_parity", {3'b110, 3'b010}, 6'b110010);

    xfer_cyc.delete();
    send_frame(one, 1'b0);
    send_frame(z, 1'b0);
    drain();
    chk("b2b_count", xfer_cyc.size(), 14);
    if (xfer_cyc.size() == 14) chk("b2b_span", xfer_cyc[13] - xfer_cyc[0], 13);

    for (int i = 0; i < 3; i++) begin
      m[i] = 3'($urandom_range(1, 7));
      e.d  = m[i];
      e.l  = 1'b0;
      exp_q.push_back(e);
      send_sym(m[i]);
    end
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_flush", exp_q.size(), 0);
    send_frame(one, 1'b0);
    drain();

    rand_ready = 1'b1;
    for (int f = 0; f < 1000; f++) begin
      for (int i = 0; i < 5; i++) m[i] = 3'($urandom_range(0, 7));
      send_frame(m, 1'b1);
    end
    drain();
    rand_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    chk("final_idle", out_valid, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/rs_encoder_stream.md
# rs_encoder_stream

Streaming systematic Reed-Solomon RS(7,5) encoder over GF(2^3), primitive polynomial x^3+x+1. It is the transmit-side counterpart of the syndrome-computing decoder front end. Each frame takes K=5 message symbols over a valid/ready input. It emits N=7 codeword symbols on a registered valid/ready output: the 5 message symbols unchanged, followed by 2 parity symbols. Any codeword it produces yields zero syndromes s1 and s2 at the decoder.

## Interface
Parameters:
- SYMBOL_WIDTH, 3, bits per symbol; only 3 is supported.
- N, 7, codeword length in symbols.
- K, 5, message length in symbols; N-K=2 parity symbols.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  reset, synchronous and active-high.
- in_valid  in  1  in_data holds a message symbol.
- in_ready  out  1  the encoder accepts in_data this cycle.
- in_data  in  SYMBOL_WIDTH  message symbol; the first symbol of a frame is the x^6 coefficient.
- out_valid  out  1  out_data holds a codeword symbol.
- out_ready  in  1  the downstream block consumes out_data this cycle.
- out_data  out  SYMBOL_WIDTH  codeword symbol, in order x^6 down to x^0.
- out_last  out  1  high with the 7th symbol (x^0 parity) of each codeword.

## Operation
- Generator polynomial: g(x) = (x+α)(x+α^2) = x^2 + α^4·x + α^3.
  - G1 = α^4 = 3'b110.
  - G0 = α^3 = 3'b011.
- Output slot is free when (!out_valid || out_ready).
- Accept condition: in_valid && in_ready.
- States are MSG and PARITY, plus a 1-bit parity index pidx.
- MSG state:
  - in_ready = slot free.
  - On accept: out_data <= in_data; out_valid <= 1; out_last <= 0; msg_cnt increments.
  - On accept, LFSR update with f = in_data ^ r1:
    - r1 <= r0 ^ (f·G1)
    - r0 <= f·G0
  - On the 5th accept (msg_cnt==K-1): msg_cnt <= 0, state goes to PARITY, pidx <= 0.
- PARITY state:
  - in_ready = 0.
  - pidx=0, slot free: out_data <= r1; out_valid <= 1; out_last <= 0; pidx <= 1.
  - pidx=1, slot free: out_data <= r0; out_valid <= 1; out_last <= 1; r1, r0 <= 0; state goes to MSG.
- Slot free with nothing to load (MSG with no accept): out_valid <= 0.
- Holding rule: while out_valid && !out_ready, out_data, out_valid and out_last hold.
- GF arithmetic:
  - Addition is XOR.
  - Multiplication by a constant is a fixed 3x3 XOR network modulo x^3+x+1.
  - All values are exactly SYMBOL_WIDTH bits; there is no carry or widening.
- in_data is ignored when in_valid=0. A message symbol is never dropped or duplicated.

## Timing
- Reset values: out_valid=0, out_last=0, out_data=0, in_ready=0 during the reset cycle, state=MSG, msg_cnt=0, r1=r0=0.
  - in_ready may assert the first cycle after rst deasserts.
- Latency: an accepted symbol appears on out_data in the next cycle.
- Parity 1 is loaded in the cycle after the 5th accept; parity 0 is loaded the cycle after that, if out_ready stays high.
- Throughput: 7 cycles per frame with continuous in_valid and out_ready.
  - The first symbol of the next frame is accepted in the cycle after parity 0 is loaded. No bubble is required beyond the 2 parity slots.
- in_ready depends combinationally on out_ready, with no path from in_valid.
- Backpressure in PARITY: the parity symbols wait until the slot is free; the LFSR is frozen.
- Reset mid-frame or mid-parity:
  - The partial frame is discarded; all state returns to its reset value next cycle.
  - The next accepted symbol is treated as a frame start.
- Gaps in in_valid mid-frame: the LFSR and msg_cnt hold; there is no timeout.

## Structure
- Package rs_pkg holds:
  - SYMBOL_WIDTH, N, K.
  - PRIM_POLY = 4'b1011.
  - Constants G1 and G0.
  - The state enum {MSG, PARITY}.
  - A function gf8_mul(a,b) for reuse by the decoder side.
- Sub-module gf8_const_mul is natural: a combinational multiply-by-constant with the constant as a parameter, instantiated twice (G1 and G0).
- The top level holds the FSM, msg_cnt (3 bits), pidx, the LFSR and the output register.

## Test plan
- Reset: assert rst with in_valid=1 for 2 cycles -> out_valid=0, out_last=0, in_ready=0; after release in_ready=1 with out_ready=1.
- All-zero message 0,0,0,0,0, out_ready=1 -> outputs 0,0,0,0,0,0,0 on consecutive cycles; out_last only on the 7th.
- Message 1,0,0,0,0 -> 1,0,0,0,0,3'b110,3'b010. The scoreboard checks that s1 = c(α) = 0 and s2 = c(α^2) = 0 for every frame.
- Back-to-back frames 1,0,0,0,0 then 0,0,0,0,0 with continuous valid/ready -> the second frame gives 0,0,0,0,0,0,0, proving the LFSR clears; 14 output cycles with no extra bubble.
- Random out_ready (50%) plus random in_valid gaps over 1000 random frames -> output equals the reference-model codewords, out_data is stable while stalled, and there is no loss or duplication.
- rst pulsed after the 3rd message symbol, then 1,0,0,0,0 sent -> exactly 1,0,0,0,0,3'b110,3'b010 emitted after reset, with no stale parity.
